// File: rtl/xover_coef_ctrl_if.sv
// Host/filter-side bundle for xover_coef_ctrl: shadow write port, commit/sync, active coefficients.
// Optional readback signals exist only when XOVER_COEF_READBACK_EN is defined.
interface xover_coef_ctrl_if #(
    parameter int unsigned NBITS = 32
);
    logic                    i_wr_en;
    logic [3:0]              i_wr_addr;
    logic signed [NBITS-1:0] i_wr_data;
    logic                    i_commit;
    logic                    i_sample_valid;

    logic signed [NBITS-1:0] o_lp_a0;
    logic signed [NBITS-1:0] o_lp_a1;
    logic signed [NBITS-1:0] o_lp_a2;
    logic signed [NBITS-1:0] o_lp_b1;
    logic signed [NBITS-1:0] o_lp_b2;
    logic signed [NBITS-1:0] o_hp_a0;
    logic signed [NBITS-1:0] o_hp_a1;
    logic signed [NBITS-1:0] o_hp_a2;
    logic signed [NBITS-1:0] o_hp_b1;
    logic signed [NBITS-1:0] o_hp_b2;
    logic                    o_pending;
    logic                    o_swap_done;
    logic                    o_wr_err;
    logic                    o_timeout;

`ifdef XOVER_COEF_READBACK_EN
    logic                    i_rd_sel;
    logic [NBITS-1:0]        o_rd_data;
`endif

    // Host / testbench side
    modport master (
`ifdef XOVER_COEF_READBACK_EN
        output i_rd_sel,
        input  o_rd_data,
`endif
        output i_wr_en, i_wr_addr, i_wr_data, i_commit, i_sample_valid,
        input  o_lp_a0, o_lp_a1, o_lp_a2, o_lp_b1, o_lp_b2,
        input  o_hp_a0, o_hp_a1, o_hp_a2, o_hp_b1, o_hp_b2,
        input  o_pending, o_swap_done, o_wr_err, o_timeout
    );

    // Controller side
    modport slave (
`ifdef XOVER_COEF_READBACK_EN
        input  i_rd_sel,
        output o_rd_data,
`endif
        input  i_wr_en, i_wr_addr, i_wr_data, i_commit, i_sample_valid,
        output o_lp_a0, o_lp_a1, o_lp_a2, o_lp_b1, o_lp_b2,
        output o_hp_a0, o_hp_a1, o_hp_a2, o_hp_b1, o_hp_b2,
        output o_pending, o_swap_done, o_wr_err, o_timeout
    );
endinterface

// File: rtl/xover_coef_ctrl.sv
// Crossover biquad coefficient bank: host writes a shadow bank, commit swaps it into the active
// bank atomically on a sample boundary (or after a timeout). Readback via XOVER_COEF_READBACK_EN.
module xover_coef_ctrl #(
    parameter int unsigned NBITS       = 32,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input logic              i_mck,
    input logic              i_rstn,
    xover_coef_ctrl_if.slave bus
);
    localparam int unsigned    NCOEF    = 10;
    localparam int unsigned    CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic {
        S_IDLE,
        S_PENDING
    } state_e;

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic signed [NBITS-1:0] shadow_q [NCOEF];
    logic signed [NBITS-1:0] active_q [NCOEF];
    logic                    pending_q;
    logic                    swap_done_q;
    logic                    wr_err_q;
    logic                    timeout_q;

    logic addr_ok_c;
    logic wr_ok_c;
    logic force_c;
    logic load_c;

    // Write acceptance and swap qualification for the current edge
    always_comb begin
        addr_ok_c = 1'b0;
        wr_ok_c   = 1'b0;
        force_c   = 1'b0;
        load_c    = 1'b0;
        addr_ok_c = (bus.i_wr_addr < 4'(NCOEF));
        wr_ok_c   = bus.i_wr_en && addr_ok_c && (state_q == S_IDLE);
        force_c   = (state_q == S_PENDING) && !bus.i_sample_valid && (cnt_q == CNT_LAST);
        load_c    = (state_q == S_PENDING) && (bus.i_sample_valid || force_c);
    end

    // Control FSM, shadow/active banks and status pulses
    always_ff @(posedge i_mck or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            pending_q   <= 1'b0;
            swap_done_q <= 1'b0;
            wr_err_q    <= 1'b0;
            timeout_q   <= 1'b0;
            for (int i = 0; i < int'(NCOEF); i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            swap_done_q <= 1'b0;
            timeout_q   <= 1'b0;
            wr_err_q    <= bus.i_wr_en && !wr_ok_c;

            // A write coincident with commit lands first, so it rides along with the commit
            if (wr_ok_c) begin
                shadow_q[bus.i_wr_addr] <= bus.i_wr_data;
            end

            case (state_q)
                S_IDLE: begin
                    if (bus.i_commit) begin
                        state_q   <= S_PENDING;
                        pending_q <= 1'b1;
                        cnt_q     <= '0;
                    end
                end
                S_PENDING: begin
                    if (load_c) begin
                        for (int i = 0; i < int'(NCOEF); i++) begin
                            active_q[i] <= shadow_q[i];
                        end
                        state_q     <= S_IDLE;
                        pending_q   <= 1'b0;
                        swap_done_q <= 1'b1;
                        timeout_q   <= force_c;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    pending_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_lp_a0     = active_q[0];
    assign bus.o_lp_a1     = active_q[1];
    assign bus.o_lp_a2     = active_q[2];
    assign bus.o_lp_b1     = active_q[3];
    assign bus.o_lp_b2     = active_q[4];
    assign bus.o_hp_a0     = active_q[5];
    assign bus.o_hp_a1     = active_q[6];
    assign bus.o_hp_a2     = active_q[7];
    assign bus.o_hp_b1     = active_q[8];
    assign bus.o_hp_b2     = active_q[9];
    assign bus.o_pending   = pending_q;
    assign bus.o_swap_done = swap_done_q;
    assign bus.o_wr_err    = wr_err_q;
    assign bus.o_timeout   = timeout_q;

`ifdef XOVER_COEF_READBACK_EN
    logic [NBITS-1:0] rd_data_q;

    // Registered readback of the addressed register; reserved addresses read as zero
    always_ff @(posedge i_mck or negedge i_rstn) begin
        if (!i_rstn) begin
            rd_data_q <= '0;
        end else if (!addr_ok_c) begin
            rd_data_q <= '0;
        end else if (bus.i_rd_sel) begin
            rd_data_q <= active_q[bus.i_wr_addr];
        end else begin
            rd_data_q <= shadow_q[bus.i_wr_addr];
        end
    end

    assign bus.o_rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_xover_coef_ctrl.sv
// Randomized + directed bench for xover_coef_ctrl against a cycle-count based bank model.
// Readback checks are compiled in when XOVER_COEF_READBACK_EN is defined.
module tb_xover_coef_ctrl;
    localparam int unsigned TO = 4096;

    logic clk;
    logic rstn;
    int   n_vec;
    int   n_err;

    xover_coef_ctrl_if #(.NBITS(32)) bus ();

    xover_coef_ctrl #(
        .NBITS      (32),
        .TIMEOUT_CYC(TO)
    ) dut (
        .i_mck (clk),
        .i_rstn(rstn),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    // Reference model: banks as arrays, timeout tracked as age of the commit in cycles
    logic [31:0] m_sh  [10];
    logic [31:0] m_act [10];
    bit          m_pend;
    int          cyc;
    int          commit_cyc;
    bit          exp_swap;
    bit          exp_to;
    bit          exp_err;
    logic [31:0] exp_rd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 10; i++) begin
            m_sh[i]  = '0;
            m_act[i] = '0;
        end
        m_pend   = 1'b0;
        exp_swap = 1'b0;
        exp_to   = 1'b0;
        exp_err  = 1'b0;
        exp_rd   = '0;
    endtask

    task automatic model_edge(input logic we, input logic [3:0] a, input logic [31:0] d,
                              input logic cm, input logic sv, input logic rs);
        cyc++;
        exp_rd   = (a < 4'd10) ? (rs ? m_act[int'(a)] : m_sh[int'(a)]) : 32'd0;
        exp_swap = 1'b0;
        exp_to   = 1'b0;
        exp_err  = 1'b0;
        if (m_pend) begin
            exp_err = we;
            if (sv || (cyc - commit_cyc == int'(TO))) begin
                m_act    = m_sh;
                m_pend   = 1'b0;
                exp_swap = 1'b1;
                exp_to   = !sv;
            end
        end else begin
            if (we) begin
                if (a < 4'd10) m_sh[int'(a)] = d;
                else exp_err = 1'b1;
            end
            if (cm) begin
                m_pend     = 1'b1;
                commit_cyc = cyc;
            end
        end
    endtask

    task automatic check_all();
        logic [31:0] got [10];
        got[0] = bus.o_lp_a0; got[1] = bus.o_lp_a1; got[2] = bus.o_lp_a2;
        got[3] = bus.o_lp_b1; got[4] = bus.o_lp_b2; got[5] = bus.o_hp_a0;
        got[6] = bus.o_hp_a1; got[7] = bus.o_hp_a2; got[8] = bus.o_hp_b1;
        got[9] = bus.o_hp_b2;
        for (int i = 0; i < 10; i++) chk($sformatf("coef%0d", i), got[i], m_act[i]);
        chk("pending",   32'(bus.o_pending),   32'(m_pend));
        chk("swap_done", 32'(bus.o_swap_done), 32'(exp_swap));
        chk("wr_err",    32'(bus.o_wr_err),    32'(exp_err));
        chk("timeout",   32'(bus.o_timeout),   32'(exp_to));
`ifdef XOVER_COEF_READBACK_EN
        chk("rd_data",   bus.o_rd_data,        exp_rd);
`endif
    endtask

    task automatic step(input logic we, input logic [3:0] a, input logic [31:0] d,
                        input logic cm, input logic sv, input logic rs);
        @(negedge clk);
        bus.i_wr_en        = we;
        bus.i_wr_addr      = a;
        bus.i_wr_data      = d;
        bus.i_commit       = cm;
        bus.i_sample_valid = sv;
`ifdef XOVER_COEF_READBACK_EN
        bus.i_rd_sel       = rs;
`endif
        @(posedge clk);
        model_edge(we, a, d, cm, sv, rs);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Asserts reset mid-cycle and checks outputs clear asynchronously
    task automatic apply_reset();
        @(negedge clk);
        bus.i_wr_en        = 1'b0;
        bus.i_commit       = 1'b0;
        bus.i_sample_valid = 1'b0;
        rstn = 1'b0;
        #2;
        model_reset();
        check_all();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic rand_phase(input int n, input int sv_div);
        for (int i = 0; i < n; i++) begin
            step(($urandom % 3) == 0, 4'($urandom_range(0, 15)), $urandom,
                 ($urandom % 8) == 0, ($urandom % sv_div) == 0, 1'($urandom));
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        commit_cyc = 0;
        rstn = 1'b0;
        bus.i_wr_en = 1'b0;
        bus.i_wr_addr = '0;
        bus.i_wr_data = '0;
        bus.i_commit = 1'b0;
        bus.i_sample_valid = 1'b0;
`ifdef XOVER_COEF_READBACK_EN
        bus.i_rd_sel = 1'b0;
`endif
        model_reset();
        #13;
        check_all();
        apply_reset();

        // Single write, commit, sync 20 cycles later
        step(1'b1, 4'd0, 32'h0040_0000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        idle(19);
        step(1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 1'b1);
        chk("lp_a0_direct", bus.o_lp_a0, 32'h0040_0000);
        idle(2);

        // Full bank, write attempt while pending is rejected
        for (int i = 0; i < 10; i++) step(1'b1, 4'(i), 32'(i + 1), 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 4'd3, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0);
        idle(3);
        step(1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        chk("lp_b1_direct", bus.o_lp_b1, 32'd4);
        chk("hp_b2_direct", bus.o_hp_b2, 32'd10);

        // Reserved address write
        step(1'b1, 4'd12, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Write + commit same cycle, commit + sync same cycle
        step(1'b1, 4'd9, 32'hCAFE_0009, 1'b1, 1'b1, 1'b0);
        idle(4);
        step(1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 1'b1);
        idle(2);

        // Forced swap on timeout, with an ignored re-commit on the way
        step(1'b1, 4'd5, 32'h8000_0001, 1'b1, 1'b0, 1'b0);
        idle(100);
        step(1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        idle(int'(TO) + 4);

        // Reset while pending drops the commit
        step(1'b1, 4'd1, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
        idle(5);
        apply_reset();
        step(1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 1'b1);
        idle(2);

        rand_phase(3000, 12);
        rand_phase(6000, 5000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
